// File: rtl/simplepiano_pkg.sv
// Shared constants and types for the tone decoder: note thresholds, silence encoding, FSM states.
package simplepiano_pkg;

   // Lower bound of each note band for a working value normalised into [31474, 65535*2).
   localparam logic [11:0][15:0] NOTE_THRESH = {
      16'd31474, 16'd33346, 16'd35328, 16'd37429, 16'd39655, 16'd42013,
      16'd44511, 16'd47158, 16'd49962, 16'd52933, 16'd56080, 16'd59415
   };

   localparam logic [3:0] NO_NOTE    = 4'hF;
   localparam logic [3:0] LAST_NOTE  = 4'd11;
   localparam logic [2:0] MAX_OCTAVE = 3'd7;

   typedef enum logic [1:0] {
      StIdle,
      StNorm,
      StScan,
      StCommit
   } dec_state_e;

   function automatic logic [16:0] thresh(input logic [3:0] n);
      logic [16:0] t;
      case (n)
         4'd0:    t = {1'b0, NOTE_THRESH[0]};
         4'd1:    t = {1'b0, NOTE_THRESH[1]};
         4'd2:    t = {1'b0, NOTE_THRESH[2]};
         4'd3:    t = {1'b0, NOTE_THRESH[3]};
         4'd4:    t = {1'b0, NOTE_THRESH[4]};
         4'd5:    t = {1'b0, NOTE_THRESH[5]};
         4'd6:    t = {1'b0, NOTE_THRESH[6]};
         4'd7:    t = {1'b0, NOTE_THRESH[7]};
         4'd8:    t = {1'b0, NOTE_THRESH[8]};
         4'd9:    t = {1'b0, NOTE_THRESH[9]};
         4'd10:   t = {1'b0, NOTE_THRESH[10]};
         4'd11:   t = {1'b0, NOTE_THRESH[11]};
         default: t = '1;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises tone_in, detects rising edges and measures edge-to-edge period in clk cycles.
module tone_period_meter
   import simplepiano_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        tone_in,
   output logic        per_stb,
   output logic [15:0] per_val,
   output logic        timeout
);

   logic        sync1_q, sync2_q, prev_q;
   logic        armed_q, armed_d;
   logic [15:0] cnt_q, cnt_d;
   logic        rise;

   assign rise    = sync2_q & ~prev_q;
   assign per_val = cnt_q;

   always_comb begin
      armed_d = armed_q;
      cnt_d   = cnt_q;
      per_stb = 1'b0;
      timeout = 1'b0;
      if (!ena) begin
         armed_d = 1'b0;
         cnt_d   = '0;
      end else begin
         timeout = armed_q && (cnt_q == 16'hFFFF);
         // A rise coinciding with timeout only re-arms; the saturated count is not a period.
         if (rise) begin
            armed_d = 1'b1;
            cnt_d   = 16'd1;
            per_stb = armed_q && !timeout;
         end else if (timeout) begin
            armed_d = 1'b0;
         end else if (armed_q) begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= tone_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/tone_decoder.sv
// Decodes a square-wave tone period into note/octave, requiring two matching measurements.
module tone_decoder
   import simplepiano_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        tone_in,
   output logic [3:0]  note,
   output logic [3:0]  octave,
   output logic        valid,
   output logic        note_stb,
   output logic [15:0] period
);

   logic        per_stb;
   logic [15:0] per_val;
   logic        to_pulse;

   tone_period_meter u_meter (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .tone_in (tone_in),
      .per_stb (per_stb),
      .per_val (per_val),
      .timeout (to_pulse)
   );

   dec_state_e  state_q, state_d;
   logic [16:0] w_q, w_d;
   logic [2:0]  oct_q, oct_d;
   logic [3:0]  idx_q, idx_d;
   logic        oor_q, oor_d;
   logic [3:0]  cand_note_q, cand_note_d;
   logic [2:0]  cand_oct_q, cand_oct_d;
   logic        cand_vld_q, cand_vld_d;
   logic [3:0]  note_q, note_d;
   logic [3:0]  octave_q, octave_d;
   logic        valid_q, valid_d;
   logic        stb_q, stb_d;
   logic [15:0] period_q, period_d;
   logic [16:0] w_sh;
   logic [2:0]  oct_inc;

   assign w_sh    = w_q << 1;
   assign oct_inc = oct_q + 3'd1;

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      oct_d       = oct_q;
      idx_d       = idx_q;
      oor_d       = oor_q;
      cand_note_d = cand_note_q;
      cand_oct_d  = cand_oct_q;
      cand_vld_d  = cand_vld_q;
      note_d      = note_q;
      octave_d    = octave_q;
      valid_d     = valid_q;
      period_d    = period_q;

      if (!ena || to_pulse) begin
         state_d    = StIdle;
         note_d     = NO_NOTE;
         octave_d   = '0;
         valid_d    = 1'b0;
         cand_vld_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (per_stb) begin
                  period_d = per_val;
                  w_d      = {1'b0, per_val};
                  oct_d    = '0;
                  idx_d    = '0;
                  oor_d    = 1'b0;
                  state_d  = StNorm;
               end
            end
            StNorm: begin
               // Shift and decide exit in the same cycle so 7 shifts cost 7 cycles.
               if (w_q < thresh(LAST_NOTE) && oct_q < MAX_OCTAVE) begin
                  w_d   = w_sh;
                  oct_d = oct_inc;
                  oor_d = w_sh < thresh(LAST_NOTE);
                  if (!oor_d || oct_inc == MAX_OCTAVE) state_d = StScan;
               end else begin
                  oor_d   = w_q < thresh(LAST_NOTE);
                  state_d = StScan;
               end
            end
            StScan: begin
               if (oor_q || w_q >= thresh(idx_q) || idx_q == LAST_NOTE) begin
                  state_d = StCommit;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
            StCommit: begin
               state_d = StIdle;
               if (oor_q) begin
                  note_d     = NO_NOTE;
                  octave_d   = '0;
                  valid_d    = 1'b0;
                  cand_vld_d = 1'b0;
               end else if (cand_vld_q && cand_note_q == idx_q && cand_oct_q == oct_q) begin
                  note_d   = idx_q;
                  octave_d = {1'b0, oct_q};
                  valid_d  = 1'b1;
               end else begin
                  cand_note_d = idx_q;
                  cand_oct_d  = oct_q;
                  cand_vld_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      stb_d = (note_d != note_q) || (octave_d != octave_q) || (valid_d != valid_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         w_q         <= '0;
         oct_q       <= '0;
         idx_q       <= '0;
         oor_q       <= 1'b0;
         cand_note_q <= NO_NOTE;
         cand_oct_q  <= '0;
         cand_vld_q  <= 1'b0;
         note_q      <= NO_NOTE;
         octave_q    <= '0;
         valid_q     <= 1'b0;
         stb_q       <= 1'b0;
         period_q    <= '0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         oct_q       <= oct_d;
         idx_q       <= idx_d;
         oor_q       <= oor_d;
         cand_note_q <= cand_note_d;
         cand_oct_q  <= cand_oct_d;
         cand_vld_q  <= cand_vld_d;
         note_q      <= note_d;
         octave_q    <= octave_d;
         valid_q     <= valid_d;
         stb_q       <= stb_d;
         period_q    <= period_d;
      end
   end

   assign note     = note_q;
   assign octave   = octave_q;
   assign valid    = valid_q;
   assign note_stb = stb_q;
   assign period   = period_q;

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single design clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ena, input, 1 bit: block enable; 0 forces the silence state synchronously.
REQ-004 SHALL have port tone_in, input, 1 bit: asynchronous square-wave tone to decode.
REQ-005 SHALL have port note, output, 4 bits: decoded note index 0..11; 4'hF = no note.
REQ-006 SHALL have port octave, output, 4 bits: decoded octave 0..7.
REQ-007 SHALL have port valid, output, 1 bit: note/octave are stable and meaningful.
REQ-008 SHALL have port note_stb, output, 1 bit: one-cycle pulse whenever {valid,note,octave} changes.
REQ-009 SHALL have port period, output, 16 bits: last measured rising-edge-to-rising-edge period in clk cycles.

Function
REQ-010 tone_in SHALL pass a 2-flop synchronizer; rising edge detected on synchronized signal (3 cycles input-to-edge latency).
REQ-011 16-bit period counter SHALL reset to 1 on each rising edge, increment otherwise, saturate at 65535.
REQ-012 Counter reaching 65535 SHALL be a timeout: silence state (valid=0, note=4'hF, octave=0), measurement armed-off.
REQ-013 First rising edge after reset, ena rise or timeout SHALL only arm the counter; no period produced.
REQ-014 Each subsequent rising edge SHALL capture counter value into period and start the decode FSM.
REQ-015 Decode FSM states: IDLE -> NORM -> SCAN -> COMMIT -> IDLE.
REQ-016 NORM: working value w=period (17 bits), oct=0; while w < NOTE_THRESH[11] and oct < 7, w<<=1, oct++ (one step per cycle).
REQ-017 NORM exit with w < NOTE_THRESH[11] SHALL mark the measurement out-of-range (treated as silence in COMMIT).
REQ-018 SCAN: one table entry per cycle, n=0..11; note = first n with w >= NOTE_THRESH[n].
REQ-019 NOTE_THRESH[n] = round(61156 * 2^(-(n+0.5)/12)); note 0 has no upper bound.
REQ-020 COMMIT: candidate equal to previous candidate SHALL drive note/octave with valid=1; otherwise outputs unchanged, candidate stored.
REQ-021 Out-of-range candidate SHALL drive silence state immediately in COMMIT.
REQ-022 note_stb SHALL pulse in the cycle after any output change, never otherwise.
REQ-023 Rising edge arriving while FSM not IDLE SHALL restart the counter but its period SHALL be discarded.
REQ-024 Worst-case decode latency edge-capture-to-output SHALL be 1+7+12+1 = 21 cycles.
REQ-025 Timeout or ena=0 while FSM busy SHALL abort decode to IDLE and force silence.

Reset
REQ-026 rst_n low SHALL asynchronously set note=4'hF, octave=0, valid=0, note_stb=0, period=0, FSM=IDLE, counter disarmed, synchronizer flops=0, stored candidate=none.
REQ-027 Reset deassertion SHALL require a fresh arming edge (REQ-013) before any period.

Structure
REQ-028 Shared package simplepiano_pkg SHALL hold NOTE_THRESH[0..11], NO_NOTE=4'hF, MAX_OCTAVE=7, decode FSM state enum.
REQ-029 Sub-module tone_period_meter SHALL contain synchronizer, edge detect, counter, timeout; outputs period strobe + value.

Verification
REQ-030 Reset, then tone_in period 21622 cycles x3 -> after 3rd edge + <=21 cycles: valid=1, note=6, octave=1, single note_stb.
REQ-031 Period 61156 x3 -> note=0, octave=0, valid=1; then period 30578 x2 -> note=0, octave=1, one note_stb on change.
REQ-032 Valid note, then tone_in held low -> after 65535 cycles valid=0, note=4'hF, one note_stb.
REQ-033 Period 20 cycles -> out-of-range: valid stays 0, note=4'hF, no note_stb.
REQ-034 Alternating periods 43244/21622 -> candidates never match twice, valid stays 0.
REQ-035 rst_n asserted mid-SCAN with valid=1 -> all outputs reset asynchronously; first edge after release produces no decode.
